// File: rtl/alarm_timer.sv
// alarm_timer: countdown stage behind the time-parameter register block.
// Selects a programmed delay via `interval`, captures the returned `value`
// (seconds) in LOAD, then counts it down on an internal 1 Hz prescaler and
// pulses `expired` once when the count reaches zero.
module alarm_timer #(
  parameter int unsigned ONE_HZ_DIV = 50000000,
  parameter int unsigned DIV_W      = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval_sel,
  input  logic       cancel,
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       one_hz_enable
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned SEC_W = 4;

  // Prescaler value on which the one-second tick fires.
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ONE_HZ_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [SEL_W-1:0]   interval_q,  interval_d;
  logic [SEC_W-1:0]   remaining_q, remaining_d;
  logic [DIV_W-1:0]   presc_q,     presc_d;
  logic               expired_q,   expired_d;
  logic               busy_q,      busy_d;
  logic               one_hz_q,    one_hz_d;

  // Next-state and next-output logic; start beats cancel, cancel beats counting.
  always_comb begin
    state_d     = state_q;
    interval_d  = interval_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    expired_d   = 1'b0;
    one_hz_d    = 1'b0;

    if (start_timer) begin
      // (Re)start from any state; an aborted count never expires.
      interval_d  = interval_sel;
      remaining_d = '0;
      presc_d     = '0;
      state_d     = LOAD;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Hold everything; interval keeps its last selection.
        end

        LOAD: begin
          if (cancel) begin
            state_d     = IDLE;
            remaining_d = '0;
            presc_d     = '0;
          end else if (value != '0) begin
            // Parameter block output is combinational from interval, so valid now.
            remaining_d = value;
            presc_d     = '0;
            state_d     = COUNT;
          end else begin
            // Zero-length delay expires straight out of LOAD.
            expired_d = 1'b1;
            state_d   = IDLE;
          end
        end

        COUNT: begin
          if (cancel) begin
            state_d     = IDLE;
            remaining_d = '0;
            presc_d     = '0;
          end else if (presc_q == DIV_LAST) begin
            presc_d     = '0;
            one_hz_d    = 1'b1;
            remaining_d = remaining_q - SEC_W'(1);
            if (remaining_q == SEC_W'(1)) begin
              expired_d = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end

        default: begin
          state_d     = IDLE;
          remaining_d = '0;
          presc_d     = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      interval_q  <= '0;
      remaining_q <= '0;
      presc_q     <= '0;
      expired_q   <= 1'b0;
      busy_q      <= 1'b0;
      one_hz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      interval_q  <= interval_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      expired_q   <= expired_d;
      busy_q      <= busy_d;
      one_hz_q    <= one_hz_d;
    end
  end

  assign interval      = interval_q;
  assign expired       = expired_q;
  assign busy          = busy_q;
  assign remaining     = remaining_q;
  assign one_hz_enable = one_hz_q;

endmodule

// File: doc/alarm_timer.md
Name: alarm_timer

Overview:
Countdown timer stage downstream of the time-parameter register block in the vehicle alarm datapath.
- Drives `interval` to select which programmed delay the parameter block presents on `value`.
- Captures that 4-bit delay in seconds and counts it down on an internal 1 Hz prescaler.
- Emits a one-cycle `expired` pulse to the alarm control FSM when the count reaches zero.
- Also provides `busy`, the live remaining count and the per-second tick for LED blinking.

Parameters:
- ONE_HZ_DIV, default 50000000: clock cycles per one-second tick; must be >= 2. Benches use 4.
- DIV_W, default 26: prescaler counter width; must satisfy 2^DIV_W >= ONE_HZ_DIV.

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- start_timer  in  1  level sampled each edge; high = (re)start the timer with interval_sel
- interval_sel  in  2  which delay to time: 00 arm, 01 driver, 10 passenger, 11 alarm-on
- cancel  in  1  abort the count without expiry
- value  in  4  delay in seconds returned by the parameter block for `interval`
- interval  out  2  registered selector driven to the parameter block
- expired  out  1  registered one-cycle pulse when the count completes
- busy  out  1  high in LOAD and COUNT
- remaining  out  4  seconds left; 0 when idle
- one_hz_enable  out  1  registered one-cycle pulse on each second tick while counting

Behaviour:
- Reset (synchronous, edge with reset=1): state=IDLE, interval=00, remaining=0, prescaler=0, expired=0, busy=0, one_hz_enable=0. Reset overrides all other inputs in any state, including mid-count; no expired pulse results.
- States: IDLE, LOAD, COUNT.
- Start, sampled in any state (edge E0):
  - interval <= interval_sel; remaining <= 0; prescaler <= 0; state <= LOAD.
  - If this aborts a running count, no expired pulse is produced.
- Precedence: start_timer and cancel both high in the same cycle: start wins.
- Cancel (start_timer low) in LOAD or COUNT: state <= IDLE; remaining <= 0; prescaler <= 0; no expired pulse.
- LOAD (exactly one cycle, edge E1): `value` is treated as valid for the new interval at this point, because the parameter block's output is combinational from `interval`.
  - value != 0: remaining <= value; prescaler <= 0; state <= COUNT.
  - value == 0: expired <= 1; state <= IDLE (zero-length delay).
- COUNT, per edge:
  - prescaler < ONE_HZ_DIV-1: prescaler increments.
  - prescaler == ONE_HZ_DIV-1 (tick): prescaler <= 0; one_hz_enable <= 1; remaining <= remaining-1.
  - Tick with remaining == 1: remaining <= 0; expired <= 1; state <= IDLE.
- expired and one_hz_enable are otherwise 0 and are never high for two consecutive cycles.
- Latency: expired is set at edge E0 + 1 + value*ONE_HZ_DIV and is high for exactly the following cycle. This holds for value == 0 as well.
- Value capture: `value` is captured once, in LOAD. Reprogramming the parameter block during COUNT does not affect the running count.
- Range: maximum delay 15 s. remaining never underflows and never wraps.
- busy is a registered output reflecting the state after the edge: 1 in LOAD/COUNT, 0 in IDLE.
- In IDLE with no start: all counters hold; outputs stay 0 except `interval`, which holds its last value.

Test Plan (ONE_HZ_DIV=4, parameter block at defaults 6/8/15/10, start_timer a single-cycle pulse at E0):
- Reset then start, interval_sel=00 -> interval=00 after E0; remaining=6 after E1; one_hz_enable pulses at E5, E9, ..., E25; expired high only for the cycle after E25; busy drops after E25.
- Start, interval_sel=10 -> remaining=15 after E1; expired after E61, exactly one cycle; remaining reads 0 afterwards.
- Start 01, then at E10 start 11 -> no expired for the driver count; remaining=10 after E11; expired after E11+40=E51.
- Start 00; cancel pulse at E8 -> idle after E8, remaining=0, busy=0; no expired for 40 further cycles.
- Parameter block reprogrammed with arm delay 0, then start 00 -> expired high in the cycle after E1; busy low after E1; no one_hz_enable pulses.
- Reset asserted at E12 of a driver count -> all outputs 0 and interval=00 after E12; no expired; a fresh start behaves as in scenario 1.
